// File: rtl/mux_pkg.sv
// Shared definitions for the keyed-lookup stream mux: skid FSM state encoding
// and the (key,data) pair width helper.
package mux_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Width of one (key,data) pair packed into the lookup table bus
  function automatic int unsigned pair_len(input int unsigned key_len,
                                           input int unsigned data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/mux_key_lookup.sv
// Combinational priority lookup: the lowest-index pair whose key equals i_key
// supplies the data; otherwise i_default is returned with hit=0.
module mux_key_lookup
  import mux_pkg::*;
#(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic [KEY_LEN-1:0]                           i_key,
  input  logic [DATA_LEN-1:0]                          i_default,
  input  logic [NR_KEY*pair_len(KEY_LEN,DATA_LEN)-1:0] i_lut,
  output logic [DATA_LEN-1:0]                          o_data_c,
  output logic                                         o_hit_c
);

  localparam int unsigned PAIR = pair_len(KEY_LEN, DATA_LEN);

  // Scan from the highest index down so the lowest matching index is the last writer
  always_comb begin
    o_data_c = i_default;
    o_hit_c  = 1'b0;
    for (int n = int'(NR_KEY) - 1; n >= 0; n--) begin
      if (i_lut[n*PAIR+DATA_LEN +: KEY_LEN] == i_key) begin
        o_data_c = i_lut[n*PAIR +: DATA_LEN];
        o_hit_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_key_stream.sv
// Keyed lookup mux on a valid/ready stream with a two-entry skid buffer
// (main register drives out_*, skid register absorbs one beat of backpressure).
// Optional feature macro: MUX_MISS_CNT_EN adds a saturating miss counter with
// synchronous clear (miss_cnt / miss_cnt_clr ports and CNT_W parameter).
module mux_key_stream
  import mux_pkg::*;
#(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 8
`ifdef MUX_MISS_CNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [KEY_LEN-1:0]                           in_key,
  input  logic [DATA_LEN-1:0]                          in_default,
  input  logic [NR_KEY*pair_len(KEY_LEN,DATA_LEN)-1:0] in_lut,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_LEN-1:0]                          out_data,
  output logic                                         out_hit
`ifdef MUX_MISS_CNT_EN
  ,
  output logic [CNT_W-1:0]                             miss_cnt,
  input  logic                                         miss_cnt_clr
`endif
);

  logic [ST_W-1:0]     r_state;
  logic [ST_W-1:0]     w_state_nxt;
  logic [DATA_LEN-1:0] r_main_data;
  logic                r_main_hit;
  logic [DATA_LEN-1:0] r_skid_data;
  logic                r_skid_hit;
  logic [DATA_LEN-1:0] w_data_c;
  logic                w_hit_c;
  logic                w_accept;
  logic                w_pop;
  logic                w_load_main;
  logic                w_load_skid;
  logic                w_skid_to_main;

  // Resolve the incoming key against the table
  mux_key_lookup #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_lookup (
    .i_key     (in_key),
    .i_default (in_default),
    .i_lut     (in_lut),
    .o_data_c  (w_data_c),
    .o_hit_c   (w_hit_c)
  );

  // Handshake decode straight from the state register
  always_comb begin
    in_ready  = (r_state != ST_TWO);
    out_valid = (r_state != ST_EMPTY);
    w_accept  = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
  end

  // Skid FSM next-state and register load controls
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_pop) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_accept && w_pop) begin
          w_load_main = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Main and skid data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_hit  <= 1'b0;
      r_skid_data <= '0;
      r_skid_hit  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_data_c;
        r_main_hit  <= w_hit_c;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_hit  <= r_skid_hit;
      end
      if (w_load_skid) begin
        r_skid_data <= w_data_c;
        r_skid_hit  <= w_hit_c;
      end
    end
  end

  assign out_data = r_main_data;
  assign out_hit  = r_main_hit;

`ifdef MUX_MISS_CNT_EN
  logic [CNT_W-1:0] r_miss_cnt;

  // Saturating count of accepted misses; clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_miss_cnt <= '0;
    else if (miss_cnt_clr)                           r_miss_cnt <= '0;
    else if (w_accept && !w_hit_c && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
  end

  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_mux_key_stream.sv
// Directed self-checking bench for mux_key_stream (default parameters).
// With MUX_MISS_CNT_EN defined the DUT is built with CNT_W=2 and the
// saturating miss counter is exercised as well.
module tb_mux_key_stream;

  localparam int unsigned NR_KEY   = 4;
  localparam int unsigned KEY_LEN  = 2;
  localparam int unsigned DATA_LEN = 8;
  localparam int unsigned LUT_W    = NR_KEY * (KEY_LEN + DATA_LEN);

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [KEY_LEN-1:0]  in_key;
  logic [DATA_LEN-1:0] in_default;
  logic [LUT_W-1:0]    in_lut;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                out_hit;
`ifdef MUX_MISS_CNT_EN
  logic [1:0]          miss_cnt;
  logic                miss_cnt_clr;
`endif

  int n_chk;
  int n_fail;

  // keys {3,2,1,0} -> data {44,33,22,11}
  localparam logic [LUT_W-1:0] LUT_BASE =
    {2'd3, 8'd44, 2'd2, 8'd33, 2'd1, 8'd22, 2'd0, 8'd11};
  // keys {3,3,1,1} -> data {44,33,22,11}; key 2 misses
  localparam logic [LUT_W-1:0] LUT_PRIO =
    {2'd3, 8'd44, 2'd3, 8'd33, 2'd1, 8'd22, 2'd1, 8'd11};

  mux_key_stream #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
`ifdef MUX_MISS_CNT_EN
    ,
    .CNT_W    (2)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_default (in_default),
    .in_lut     (in_lut),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hit    (out_hit)
`ifdef MUX_MISS_CNT_EN
    ,
    .miss_cnt     (miss_cnt),
    .miss_cnt_clr (miss_cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic h, input logic r);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(d));
      check({tag, ".out_hit"},  32'(out_hit),  32'(h));
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
  endtask

  logic [7:0] exp_stream [4];

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_key     = '0;
    in_default = '0;
    in_lut     = LUT_BASE;
    out_ready  = 1'b0;
`ifdef MUX_MISS_CNT_EN
    miss_cnt_clr = 1'b0;
`endif
    exp_stream[0] = 8'd11;
    exp_stream[1] = 8'd22;
    exp_stream[2] = 8'd33;
    exp_stream[3] = 8'd44;

    // Reset state
    step();
    step();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_data",  32'(out_data),  32'd0);
    check("rst.out_hit",   32'(out_hit),   32'd0);
`ifdef MUX_MISS_CNT_EN
    check("rst.miss_cnt",  32'(miss_cnt),  32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Streaming, back-to-back hits with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_key = KEY_LEN'(k);
      step();
      check_out($sformatf("stream%0d", k), 1'b1, exp_stream[k], 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream.drain_valid", 32'(out_valid), 32'd0);

    // Priority: lowest index wins; miss returns default
    in_lut     = LUT_PRIO;
    in_default = 8'hAA;
    in_valid   = 1'b1;
    in_key     = 2'd1;
    step();
    check_out("prio_hit", 1'b1, 8'd11, 1'b1, 1'b1);
    in_key = 2'd3;
    step();
    check_out("prio_hit3", 1'b1, 8'd33, 1'b1, 1'b1);
    in_key = 2'd2;
    step();
    check_out("prio_miss", 1'b1, 8'hAA, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    check("prio.drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: fill both entries, third beat held off, drain in order
    in_lut     = LUT_BASE;
    in_default = 8'h00;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_key     = 2'd0;
    step();
    check_out("bp_one", 1'b1, 8'd11, 1'b1, 1'b1);
    in_key = 2'd1;
    step();
    check_out("bp_two", 1'b1, 8'd11, 1'b1, 1'b0);
    in_key = 2'd2;
    step();
    check_out("bp_hold", 1'b1, 8'd11, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("bp_pop1", 1'b1, 8'd22, 1'b1, 1'b1);
    step();
    check_out("bp_pop2", 1'b1, 8'd33, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("bp.drain_valid", 32'(out_valid), 32'd0);

    // Reset while two beats are buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_key    = 2'd1;
    step();
    in_key = 2'd2;
    step();
    check("mid.pre_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.in_ready",  32'(in_ready),  32'd1);
    check("mid.out_data",  32'(out_data),  32'd0);
    check("mid.out_hit",   32'(out_hit),   32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mid.post_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_key    = 2'd3;
    step();
    check_out("mid_fresh", 1'b1, 8'd44, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("mid.no_stale", 32'(out_valid), 32'd0);

`ifdef MUX_MISS_CNT_EN
    // Saturating miss counter (CNT_W=2) and clear priority
    miss_cnt_clr = 1'b1;
    step();
    miss_cnt_clr = 1'b0;
    check("cnt.cleared", 32'(miss_cnt), 32'd0);
    in_lut     = LUT_PRIO;
    in_default = 8'hAA;
    in_valid   = 1'b1;
    in_key     = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cnt.miss%0d", k), 32'(miss_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    miss_cnt_clr = 1'b1;
    step();
    check("cnt.clr_wins", 32'(miss_cnt), 32'd0);
    miss_cnt_clr = 1'b0;
    in_key       = 2'd1;
    step();
    check("cnt.hit_no_inc", 32'(miss_cnt), 32'd0);
    in_valid = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
